alu_md: RTL and testbench
=========================

Name: alu_md

Overview:
- Parametrised, registered successor to the minicpu combinational ALU.
- Executes all existing ALU select codes with a one-cycle registered result.
- Adds an iterative multiply/divide unit: MULT, MULTU, DIV, DIVU, with architectural HI/LO registers and MFHI, MFLO, MTHI, MTLO.
- Sits in the EX stage; the pipeline stalls on Busy.

Parameters:
WIDTH, 32, datapath width; power of two, 8 or greater
SAW, 5, shift-amount width; equals log2(WIDTH)
CW, 6, iteration counter width; equals SAW+1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
RSbus  input  WIDTH  rs operand
RTbus  input  WIDTH  rt operand
Imm  input  WIDTH  sign/zero-extended immediate
UseImm  input  1  select Imm as second operand and Imm[SAW+5:6] as shift amount
SEL  input  8  operation select; mips.h select_alu_* codes plus select_alu_mult/multu/div/divu/mfhi/mflo/mthi/mtlo
Start  input  1  issue operation this cycle
ReadLabel  input  1  {L} security label, passed through unused
WriteLabel  input  1  {L} security label, passed through unused
ALUout  output  WIDTH  registered result
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register
Busy  output  1  multiply/divide in progress
Done  output  1  one-cycle pulse when ALUout, HI or LO is updated

Behaviour:
- Reset (async, any time, including mid-operation):
  - ALUout=0, HI=0, LO=0, Busy=0, Done=0, state=IDLE, counter=0.
  - An in-flight mul/div is discarded.
- Operand mux:
  - Y = UseImm ? Imm : (SEL[7] ? RSbus : RTbus).
  - SA = UseImm ? Imm[SAW+5:6] : RSbus[SAW-1:0].
- Single-cycle ops (ADD, AND, XOR, OR, NOR, SUB, SLTU, SLT, SRA, SRL, SLL):
  - Start=1 in IDLE: ALUout is loaded at the next edge; Done=1 for that one cycle.
  - Arithmetic is modulo 2^WIDTH; no overflow trap.
  - SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0, zero-extended.
  - SRA sign-fills; SRL zero-fills; SLL zero-fills.
- MFHI/MFLO: ALUout takes HI/LO at the next edge; Done pulses.
- MTHI/MTLO: HI/LO takes RSbus at the next edge; ALUout is unchanged; Done pulses.
- Undefined SEL with Start=1: ALUout=0; Done pulses.
- States: IDLE, MUL, DIV, FIX.
  - IDLE, Start and mult/multu: go to MUL.
  - IDLE, Start and div/divu: go to DIV.
  - Entering MUL or DIV: operand magnitudes latched (absolute value for signed ops, raw for unsigned); result sign latched; counter=WIDTH.
  - MUL: shift-add, one product bit per cycle into a 2*WIDTH accumulator.
  - DIV: restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; at counter==1 go to FIX.
  - FIX: apply sign correction; write HI/LO; Done=1; return to IDLE.
- Busy:
  - High on every cycle after the Start edge until the FIX edge. This is WIDTH+1 cycles.
  - Deasserts in the same cycle Done rises.
  - Total latency Start-edge to HI/LO valid is WIDTH+1 cycles.
- Signed-op results:
  - MULT: HI:LO is the full signed 2*WIDTH product.
  - DIV: quotient truncates toward zero into LO; remainder takes the dividend's sign into HI.
- Boundary cases:
  - Divide by zero (signed or unsigned): LO = all ones; HI = dividend (RSbus as issued). Takes the full latency.
  - DIV of most-negative by -1: LO = most-negative; HI = 0.
  - MUL of most-negative by most-negative: correct positive product, e.g. HI=0x40000000, LO=0 at WIDTH=32.
  - Start while Busy (any SEL): ignored. ALUout, HI, LO and state are unaffected; no Done.
  - Start=0: no state change. Done=0 except for the FIX pulse.
- Operands are sampled only on the Start edge. Input changes during Busy have no effect.

Test Plan:
1. Reset, then Start ADD with RS=5, RT=7 -> one edge later ALUout=0x0000000C, Done=1 for exactly one cycle, Busy=0.
2. MULT with RS=0xFFFFFFFD, RT=7 -> Busy=1 for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done pulse. Follow with MFLO -> ALUout=0xFFFFFFEB.
3. DIV RS=0xFFFFFFF9 (-7), RT=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU RS=0x1234, RT=0 -> LO=0xFFFFFFFF, HI=0x00001234.
4. Start MULTU 3x4, then Start ADD at cycle 5 with new operands -> ADD ignored, ALUout unchanged. HI=0, LO=0x0000000C after 33 cycles.
5. Start DIV 100/7, assert reset at cycle 10 -> Busy=0, HI=LO=ALUout=0 immediately. A new DIVU 100/7 then gives LO=14, HI=2.
6. WIDTH=16, SAW=4, CW=5: SRA RT=0x8000, UseImm, Imm[9:6]=4 -> ALUout=0xF800. MULT 0x8000 x 0x8000 -> HI=0x4000, LO=0x0000, Busy for 17 cycles.

Source files
------------

// File: rtl/alu_md.sv
// Registered EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops finish on the Start edge; MULT/DIV take WIDTH+1 cycles with Busy high.
module alu_md #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SAW   = 5,
  parameter int unsigned CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] RSbus,
  input  logic [WIDTH-1:0] RTbus,
  input  logic [WIDTH-1:0] Imm,
  input  logic             UseImm,
  input  logic [7:0]       SEL,
  input  logic             Start,
  input  logic             ReadLabel,
  input  logic             WriteLabel,
  output logic [WIDTH-1:0] ALUout,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [7:0] SEL_ADD   = 8'h00;
  localparam logic [7:0] SEL_AND   = 8'h01;
  localparam logic [7:0] SEL_XOR   = 8'h02;
  localparam logic [7:0] SEL_OR    = 8'h03;
  localparam logic [7:0] SEL_NOR   = 8'h04;
  localparam logic [7:0] SEL_SUB   = 8'h05;
  localparam logic [7:0] SEL_SLTU  = 8'h06;
  localparam logic [7:0] SEL_SLT   = 8'h07;
  localparam logic [7:0] SEL_SRA   = 8'h08;
  localparam logic [7:0] SEL_SRL   = 8'h09;
  localparam logic [7:0] SEL_SLL   = 8'h0A;
  localparam logic [7:0] SEL_MULT  = 8'h10;
  localparam logic [7:0] SEL_MULTU = 8'h11;
  localparam logic [7:0] SEL_DIV   = 8'h12;
  localparam logic [7:0] SEL_DIVU  = 8'h13;
  localparam logic [7:0] SEL_MFHI  = 8'h14;
  localparam logic [7:0] SEL_MFLO  = 8'h15;
  localparam logic [7:0] SEL_MTHI  = 8'h16;
  localparam logic [7:0] SEL_MTLO  = 8'h17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [DW-1:0]    acc, acc_nxt;
  logic [WIDTH-1:0] opa, opa_nxt;
  logic [WIDTH-1:0] dvd, dvd_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic             dz, dz_nxt;
  logic             is_div, is_div_nxt;
  logic [WIDTH-1:0] alu_nxt, hi_nxt, lo_nxt;
  logic             busy_nxt, done_nxt;

  logic [WIDTH-1:0] y;
  logic [SAW-1:0]   sa;
  logic             op_sgn;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_acc;
  logic [WIDTH:0]   div_sh, div_diff;
  logic [DW-1:0]    div_acc;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic [DW-1:0]    fix_p;
  logic             unused_labels;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // Labels ride along with the operands but do not affect the datapath.
  assign unused_labels = ReadLabel ^ WriteLabel;

  assign y      = UseImm ? Imm : (SEL[7] ? RSbus : RTbus);
  assign sa     = UseImm ? Imm[SAW+5:6] : RSbus[SAW-1:0];
  assign op_sgn = (SEL == SEL_MULT) || (SEL == SEL_DIV);
  assign x_mag  = (op_sgn && RSbus[WIDTH-1]) ? neg_w(RSbus) : RSbus;
  assign y_mag  = (op_sgn && y[WIDTH-1]) ? neg_w(y) : y;

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign mul_sum = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? opa : '0)};
  assign mul_acc = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: shift {rem, quot} left, keep the subtraction only when it does not borrow.
  assign div_sh   = {acc[DW-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opa};
  assign div_acc  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign fix_q = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign fix_r = neg_r ? neg_w(acc[DW-1:WIDTH]) : acc[DW-1:WIDTH];
  assign fix_p = neg_q ? ((~acc) + DW'(1)) : acc;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start && (SEL == SEL_MULT || SEL == SEL_MULTU))    state_nxt = S_MUL;
        else if (Start && (SEL == SEL_DIV || SEL == SEL_DIVU)) state_nxt = S_DIV;
      end
      S_MUL:   if (cnt == CW'(1)) state_nxt = S_FIX;
      S_DIV:   if (cnt == CW'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    alu_nxt    = ALUout;
    hi_nxt     = HI;
    lo_nxt     = LO;
    done_nxt   = 1'b0;
    busy_nxt   = (state_nxt != S_IDLE);
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    opa_nxt    = opa;
    dvd_nxt    = dvd;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    dz_nxt     = dz;
    is_div_nxt = is_div;
    case (state)
      S_IDLE: begin
        if (Start) begin
          done_nxt = 1'b1;
          case (SEL)
            SEL_ADD:  alu_nxt = RSbus + y;
            SEL_AND:  alu_nxt = RSbus & y;
            SEL_XOR:  alu_nxt = RSbus ^ y;
            SEL_OR:   alu_nxt = RSbus | y;
            SEL_NOR:  alu_nxt = ~(RSbus | y);
            SEL_SUB:  alu_nxt = RSbus - y;
            SEL_SLTU: alu_nxt = WIDTH'(RSbus < y);
            SEL_SLT:  alu_nxt = WIDTH'($signed(RSbus) < $signed(y));
            SEL_SRA:  alu_nxt = $unsigned($signed(RTbus) >>> sa);
            SEL_SRL:  alu_nxt = RTbus >> sa;
            SEL_SLL:  alu_nxt = RTbus << sa;
            SEL_MFHI: alu_nxt = HI;
            SEL_MFLO: alu_nxt = LO;
            SEL_MTHI: hi_nxt  = RSbus;
            SEL_MTLO: lo_nxt  = RSbus;
            SEL_MULT, SEL_MULTU: begin
              done_nxt   = 1'b0;
              opa_nxt    = x_mag;
              acc_nxt    = {{WIDTH{1'b0}}, y_mag};
              neg_q_nxt  = op_sgn & (RSbus[WIDTH-1] ^ y[WIDTH-1]);
              neg_r_nxt  = 1'b0;
              dz_nxt     = 1'b0;
              is_div_nxt = 1'b0;
              cnt_nxt    = CW'(WIDTH);
            end
            SEL_DIV, SEL_DIVU: begin
              done_nxt   = 1'b0;
              opa_nxt    = y_mag;
              acc_nxt    = {{WIDTH{1'b0}}, x_mag};
              neg_q_nxt  = op_sgn & (RSbus[WIDTH-1] ^ y[WIDTH-1]);
              neg_r_nxt  = op_sgn & RSbus[WIDTH-1];
              dz_nxt     = (y == '0);
              dvd_nxt    = RSbus;
              is_div_nxt = 1'b1;
              cnt_nxt    = CW'(WIDTH);
            end
            default:  alu_nxt = '0;
          endcase
        end
      end
      S_MUL: begin
        acc_nxt = mul_acc;
        cnt_nxt = cnt - CW'(1);
      end
      S_DIV: begin
        acc_nxt = div_acc;
        cnt_nxt = cnt - CW'(1);
      end
      S_FIX: begin
        done_nxt = 1'b1;
        if (is_div && dz) begin
          // Divide by zero reports the issued dividend rather than its magnitude.
          lo_nxt = '1;
          hi_nxt = dvd;
        end else if (is_div) begin
          lo_nxt = fix_q;
          hi_nxt = fix_r;
        end else begin
          lo_nxt = fix_p[WIDTH-1:0];
          hi_nxt = fix_p[DW-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUout <= '0;
      HI     <= '0;
      LO     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      dvd    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      is_div <= 1'b0;
    end else begin
      ALUout <= alu_nxt;
      HI     <= hi_nxt;
      LO     <= lo_nxt;
      Busy   <= busy_nxt;
      Done   <= done_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      opa    <= opa_nxt;
      dvd    <= dvd_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      dz     <= dz_nxt;
      is_div <= is_div_nxt;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md at WIDTH=32 and WIDTH=16: expected ALUout/HI/LO and
// Done latency are queued at issue and checked when Done pulses.
module tb_alu_md;

  localparam logic [7:0] SEL_ADD   = 8'h00;
  localparam logic [7:0] SEL_AND   = 8'h01;
  localparam logic [7:0] SEL_XOR   = 8'h02;
  localparam logic [7:0] SEL_OR    = 8'h03;
  localparam logic [7:0] SEL_NOR   = 8'h04;
  localparam logic [7:0] SEL_SUB   = 8'h05;
  localparam logic [7:0] SEL_SLTU  = 8'h06;
  localparam logic [7:0] SEL_SLT   = 8'h07;
  localparam logic [7:0] SEL_SRA   = 8'h08;
  localparam logic [7:0] SEL_SRL   = 8'h09;
  localparam logic [7:0] SEL_SLL   = 8'h0A;
  localparam logic [7:0] SEL_MULT  = 8'h10;
  localparam logic [7:0] SEL_MULTU = 8'h11;
  localparam logic [7:0] SEL_DIV   = 8'h12;
  localparam logic [7:0] SEL_DIVU  = 8'h13;
  localparam logic [7:0] SEL_MFHI  = 8'h14;
  localparam logic [7:0] SEL_MFLO  = 8'h15;
  localparam logic [7:0] SEL_MTHI  = 8'h16;
  localparam logic [7:0] SEL_MTLO  = 8'h17;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rs, rt, imm;
  logic        useimm, start32, start16, rl, wl, use16;
  logic [7:0]  sel;
  logic [31:0] alu32, hi32, lo32;
  logic        busy32, done32;
  logic [15:0] alu16, hi16, lo16;
  logic        busy16, done16;
  logic [31:0] o_alu, o_hi, o_lo;
  logic        o_busy, o_done;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  alu_md #(.WIDTH(32), .SAW(5), .CW(6)) dut32 (
    .clk(clk), .reset(reset), .RSbus(rs), .RTbus(rt), .Imm(imm), .UseImm(useimm),
    .SEL(sel), .Start(start32), .ReadLabel(rl), .WriteLabel(wl),
    .ALUout(alu32), .HI(hi32), .LO(lo32), .Busy(busy32), .Done(done32)
  );

  alu_md #(.WIDTH(16), .SAW(4), .CW(5)) dut16 (
    .clk(clk), .reset(reset), .RSbus(rs[15:0]), .RTbus(rt[15:0]), .Imm(imm[15:0]),
    .UseImm(useimm), .SEL(sel), .Start(start16), .ReadLabel(rl), .WriteLabel(wl),
    .ALUout(alu16), .HI(hi16), .LO(lo16), .Busy(busy16), .Done(done16)
  );

  assign o_alu  = use16 ? {16'h0, alu16} : alu32;
  assign o_hi   = use16 ? {16'h0, hi16}  : hi32;
  assign o_lo   = use16 ? {16'h0, lo16}  : lo32;
  assign o_busy = use16 ? busy16 : busy32;
  assign o_done = use16 ? done16 : done32;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one Start cycle and queue its expected result; returns on the negedge after the Start edge.
  task automatic issue(input string tag, input logic [7:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic ui,
                       input logic [31:0] ealu, input logic [31:0] ehi,
                       input logic [31:0] elo, input int elat);
    @(negedge clk);
    sel = s; rs = a; rt = b; imm = im; useimm = ui;
    if (use16) start16 = 1'b1; else start32 = 1'b1;
    sb.push_back('{tag, ealu, ehi, elo, elat});
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; start32 = 1'b0;
  endtask

  // Wait (bounded) for Done, then compare against the oldest queued expectation.
  task automatic wait_done(input int lat0);
    int   lat;
    int   bcnt;
    exp_t e;
    lat  = lat0;
    bcnt = 0;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard empty when a result was awaited");
      $fatal(1, "scoreboard empty");
    end
    e = sb.pop_front();
    while (o_done !== 1'b1 && lat < 200) begin
      if (o_busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({e.tag, ":done"}, 32'(o_done), 32'd1);
    check({e.tag, ":lat"}, 32'(lat), 32'(e.lat));
    check({e.tag, ":alu"}, o_alu, e.alu);
    check({e.tag, ":hi"}, o_hi, e.hi);
    check({e.tag, ":lo"}, o_lo, e.lo);
    check({e.tag, ":busy_at_done"}, 32'(o_busy), 32'd0);
    if (lat0 == 0) check({e.tag, ":busy_cycles"}, 32'(bcnt), 32'(e.lat));
    @(negedge clk);
    check({e.tag, ":done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; rs = '0; rt = '0; imm = '0; useimm = 1'b0; sel = SEL_ADD;
    start32 = 1'b0; start16 = 1'b0; rl = 1'b0; wl = 1'b1; use16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:alu", o_alu, 32'h0);
    check("rst:hi", o_hi, 32'h0);
    check("rst:lo", o_lo, 32'h0);
    check("rst:busy", 32'(o_busy), 32'd0);
    check("rst:done", 32'(o_done), 32'd0);
    reset = 1'b0;

    issue("add", SEL_ADD, 32'd5, 32'd7, 32'h0, 1'b0, 32'h0000000C, 32'h0, 32'h0, 0);
    wait_done(0);
    issue("mult", SEL_MULT, 32'hFFFFFFFD, 32'd7, 32'h0, 1'b0, 32'h0000000C, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    wait_done(0);
    issue("mflo", SEL_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    wait_done(0);
    issue("div_neg", SEL_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    wait_done(0);
    issue("divu_z", SEL_DIVU, 32'h1234, 32'h0, 32'h0, 1'b0, 32'hFFFFFFEB, 32'h00001234, 32'hFFFFFFFF, 33);
    wait_done(0);
    issue("div_min", SEL_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'hFFFFFFEB, 32'h0, 32'h80000000, 33);
    wait_done(0);
    issue("mult_min", SEL_MULT, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 32'hFFFFFFEB, 32'h40000000, 32'h0, 33);
    wait_done(0);
    issue("div_z", SEL_DIV, 32'hFFFFFFFB, 32'h0, 32'h0, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFB, 32'hFFFFFFFF, 33);
    wait_done(0);

    issue("sub", SEL_SUB, 32'd3, 32'd5, 32'h0, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("slt", SEL_SLT, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'h1, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("sltu", SEL_SLTU, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("and", SEL_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 32'hF000F000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("or", SEL_OR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 32'hFFF0FFF0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("xor", SEL_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 32'h0FF00FF0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("nor", SEL_NOR, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("sra", SEL_SRA, 32'd4, 32'h80000000, 32'h0, 1'b0, 32'hF8000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("srl", SEL_SRL, 32'd4, 32'h80000000, 32'h0, 1'b0, 32'h08000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("sll", SEL_SLL, 32'd31, 32'h1, 32'h0, 1'b0, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("addi", SEL_ADD, 32'd10, 32'd100, 32'hFFFFFFFF, 1'b1, 32'h9, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("slli", SEL_SLL, 32'h0, 32'h1, 32'h000000C0, 1'b1, 32'h8, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("undef", 8'h3F, 32'd1, 32'd2, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("mthi", SEL_MTHI, 32'h11111111, 32'h0, 32'h0, 1'b0, 32'h0, 32'h11111111, 32'hFFFFFFFF, 0);
    wait_done(0);
    issue("mtlo", SEL_MTLO, 32'h22222222, 32'h0, 32'h0, 1'b0, 32'h0, 32'h11111111, 32'h22222222, 0);
    wait_done(0);
    issue("mfhi", SEL_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 32'h11111111, 32'h11111111, 32'h22222222, 0);
    wait_done(0);
    issue("multu_max", SEL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h11111111, 32'hFFFFFFFE, 32'h00000001, 33);
    wait_done(0);
    issue("divu", SEL_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0, 1'b0, 32'h11111111, 32'h0000000F, 32'h0FFFFFFF, 33);
    wait_done(0);

    // Start while busy must be ignored; operand changes mid-operation must not matter.
    issue("multu_busy", SEL_MULTU, 32'd3, 32'd4, 32'h0, 1'b0, 32'h11111111, 32'h0, 32'h0000000C, 33);
    repeat (4) @(negedge clk);
    sel = SEL_ADD; rs = 32'd1; rt = 32'd2; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    check("busy_mid", 32'(o_busy), 32'd1);
    wait_done(5);

    // Reset in the middle of a divide discards it.
    issue("div_rst", SEL_DIV, 32'd100, 32'd7, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 33);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid:busy", 32'(o_busy), 32'd0);
    check("rst_mid:alu", o_alu, 32'h0);
    check("rst_mid:hi", o_hi, 32'h0);
    check("rst_mid:lo", o_lo, 32'h0);
    check("rst_mid:done", 32'(o_done), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue("divu_after", SEL_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 32'h0, 32'h2, 32'hE, 33);
    wait_done(0);

    // Narrow instance.
    use16 = 1'b1;
    issue("w16_srai", SEL_SRA, 32'h0, 32'h8000, 32'h00000100, 1'b1, 32'hF800, 32'h0, 32'h0, 0);
    wait_done(0);
    issue("w16_mult_min", SEL_MULT, 32'h8000, 32'h8000, 32'h0, 1'b0, 32'hF800, 32'h4000, 32'h0, 17);
    wait_done(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
